// File: rtl/tcl_egress_merge_pkg.sv
// Shared definitions for the 4-port egress merge: widths, port count,
// one-hot FSM encodings and the egress tagging helper.
package tcl_egress_merge_pkg;

  localparam int DATA_W    = 12;
  localparam int CNT_W     = 5;
  localparam int NUM_PORTS = 4;
  localparam int PORT_W    = 2;
  localparam int THR_W     = 3;

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_t;

  // Replace the top two bits of a word with the source port so the far-end
  // splitter can route on them.
  function automatic logic [DATA_W-1:0] tag_word(input logic [PORT_W-1:0] port,
                                                 input logic [DATA_W-1:0] word);
    return {port, word[DATA_W-PORT_W-1:0]};
  endfunction

endpackage

// File: rtl/tcl_egress_merge_fifo.sv
// Per-port circular buffer with occupancy count, threshold flags and a sticky
// overflow flag for pushes that found the buffer full.
module merge_fifo #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int THR_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  input  logic [THR_W-1:0]  umbral_alto,
  input  logic [THR_W-1:0]  umbral_bajo,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A full buffer still takes a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  assign almost_full  = (count >= (ADDR_W+1)'(umbral_alto));
  assign almost_empty = (count <= (ADDR_W+1)'(umbral_bajo));

  // Pointer, occupancy and overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Storage array; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tcl_egress_merge.sv
// Four buffered ingress ports merged round-robin into one tagged egress
// stream, with per-port and total pop counters readable in IDLE.
module tcl_egress_merge
  import tcl_egress_merge_pkg::*;
#(
  parameter int DATA_W = tcl_egress_merge_pkg::DATA_W,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = tcl_egress_merge_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [2:0]        umbral_alto,
  input  logic [2:0]        umbral_bajo,
  input  logic [3:0]        push_in,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic              ds_almost_full,
  input  logic              req,
  input  logic [2:0]        idx,
  output logic [3:0]        almost_full_out,
  output logic [3:0]        almost_empty_out,
  output logic [3:0]        overflow,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [3:0]        state,
  output logic [CNT_W-1:0]  counter_out,
  output logic              counter_valid
);

  state_t             state_q;
  state_t             state_d;
  logic [THR_W-1:0]   alto_q;
  logic [THR_W-1:0]   bajo_q;
  logic [PORT_W-1:0]  rr_ptr_q;

  logic [DATA_W-1:0]  wdata [NUM_PORTS];
  logic [DATA_W-1:0]  head  [NUM_PORTS];
  logic [NUM_PORTS-1:0] empty_vec;
  logic [NUM_PORTS-1:0] af_vec;
  logic [NUM_PORTS-1:0] ae_vec;
  logic [NUM_PORTS-1:0] push_vec;
  logic [NUM_PORTS-1:0] pop_vec;
  logic                 push_en;

  logic               grant_vld_p0;
  logic [PORT_W-1:0]  grant_p0;
  logic [PORT_W-1:0]  cand;

  logic [CNT_W-1:0]   cnt [NUM_PORTS];
  logic [CNT_W-1:0]   cnt_total;

  assign wdata[0] = data_in0;
  assign wdata[1] = data_in1;
  assign wdata[2] = data_in2;
  assign wdata[3] = data_in3;

  assign push_en  = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  assign push_vec = push_en ? push_in : '0;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_fifo
    merge_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .THR_W  (THR_W)
    ) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .push         (push_vec[g]),
      .pop          (pop_vec[g]),
      .wdata        (wdata[g]),
      .umbral_alto  (alto_q),
      .umbral_bajo  (bajo_q),
      .head         (head[g]),
      .empty        (empty_vec[g]),
      .almost_full  (af_vec[g]),
      .almost_empty (ae_vec[g]),
      .overflow     (overflow[g])
    );
  end

  // Thresholds are still zero in RESET, where the raw compare would flag an
  // empty buffer as almost full; hold the flag low until they can be loaded.
  assign almost_full_out  = (state_q == ST_RESET) ? '0 : af_vec;
  assign almost_empty_out = ae_vec;
  assign state            = state_q;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  // FSM next-state logic; queued data survives a return to INIT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init)             state_d = ST_INIT;
        else if (~&empty_vec) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (init)            state_d = ST_INIT;
        else if (&empty_vec) state_d = ST_IDLE;
      end
      default:   state_d = ST_RESET;
    endcase
  end

  // Threshold capture while INIT is requested.
  always_ff @(posedge clk) begin
    if (!reset) begin
      alto_q <= '0;
      bajo_q <= '0;
    end else if (state_q == ST_INIT && init) begin
      alto_q <= umbral_alto;
      bajo_q <= umbral_bajo;
    end
  end

  // Round-robin grant: first non-empty port at or above the pointer, wrapping.
  always_comb begin
    grant_vld_p0 = 1'b0;
    grant_p0     = rr_ptr_q;
    cand         = rr_ptr_q;
    pop_vec      = '0;
    if (state_q == ST_ACTIVE && !ds_almost_full) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        cand = rr_ptr_q + PORT_W'(k);
        if (!grant_vld_p0 && !empty_vec[cand]) begin
          grant_vld_p0 = 1'b1;
          grant_p0     = cand;
        end
      end
    end
    if (grant_vld_p0) pop_vec[grant_p0] = 1'b1;
  end

  // Pointer advances past the port just served; idle cycles leave it alone.
  always_ff @(posedge clk) begin
    if (!reset)            rr_ptr_q <= '0;
    else if (grant_vld_p0) rr_ptr_q <= grant_p0 + 1'b1;
  end

  // ---- stage p0 -> p1: egress output register ----
  // Output register: tagged head word on a pop, otherwise hold data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= grant_vld_p0;
      if (grant_vld_p0) data_out <= tag_word(grant_p0, head[grant_p0]);
    end
  end

  // Pop counters; pops only happen in ACTIVE so they only move there.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
      cnt_total <= '0;
    end else if (grant_vld_p0) begin
      cnt[grant_p0] <= cnt[grant_p0] + 1'b1;
      cnt_total     <= cnt_total + 1'b1;
    end
  end

  // Counter readback, honoured only in IDLE; counter_out holds otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      counter_out   <= '0;
      counter_valid <= 1'b0;
    end else begin
      counter_valid <= 1'b0;
      if (state_q == ST_IDLE && req) begin
        counter_valid <= 1'b1;
        counter_out   <= idx[2] ? cnt_total : cnt[idx[1:0]];
      end
    end
  end

endmodule

// File: tb/tb_tcl_egress_merge.sv
// Directed bench for tcl_egress_merge: table-driven readback and egress
// vectors plus hand-written multi-cycle sequences.
module tb_tcl_egress_merge;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [2:0]  umbral_alto;
  logic [2:0]  umbral_bajo;
  logic [3:0]  push_in;
  logic [11:0] data_in0, data_in1, data_in2, data_in3;
  logic        ds_almost_full;
  logic        req;
  logic [2:0]  idx;
  logic [3:0]  almost_full_out;
  logic [3:0]  almost_empty_out;
  logic [3:0]  overflow;
  logic [11:0] data_out;
  logic        valid_out;
  logic [3:0]  state;
  logic [4:0]  counter_out;
  logic        counter_valid;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tcl_egress_merge dut (
    .clk              (clk),
    .reset            (reset),
    .init             (init),
    .umbral_alto      (umbral_alto),
    .umbral_bajo      (umbral_bajo),
    .push_in          (push_in),
    .data_in0         (data_in0),
    .data_in1         (data_in1),
    .data_in2         (data_in2),
    .data_in3         (data_in3),
    .ds_almost_full   (ds_almost_full),
    .req              (req),
    .idx              (idx),
    .almost_full_out  (almost_full_out),
    .almost_empty_out (almost_empty_out),
    .overflow         (overflow),
    .data_out         (data_out),
    .valid_out        (valid_out),
    .state            (state),
    .counter_out      (counter_out),
    .counter_valid    (counter_valid)
  );

  typedef struct {
    logic [2:0] idx;
    logic [4:0] exp;
  } rb_vec_t;

  typedef struct {
    int          port;
    logic [11:0] data;
    logic [11:0] exp;
  } eg_vec_t;

  rb_vec_t rb_tab [8];
  eg_vec_t eg_tab [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_init(input logic [2:0] alto, input logic [2:0] bajo);
    reset = 1'b0; init = 1'b0; push_in = '0; req = 1'b0; ds_almost_full = 1'b0;
    tick(); tick();
    reset = 1'b1; init = 1'b1; umbral_alto = alto; umbral_bajo = bajo;
    tick(); tick();
    init = 1'b0;
    tick();
  endtask

  task automatic push_port(input int port, input logic [11:0] data);
    push_in = 4'b0001 << port;
    case (port)
      0: data_in0 = data;
      1: data_in1 = data;
      2: data_in2 = data;
      default: data_in3 = data;
    endcase
    tick();
    push_in = '0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (state == 4'b0100) done = 1'b1;
      else tick();
    end
    chk(name, state, 4'b0100);
  endtask

  initial begin
    int  nw;
    bit  seen;

    rb_tab[0] = '{3'd0, 5'd1};
    rb_tab[1] = '{3'd1, 5'd1};
    rb_tab[2] = '{3'd2, 5'd1};
    rb_tab[3] = '{3'd3, 5'd1};
    rb_tab[4] = '{3'd4, 5'd4};
    rb_tab[5] = '{3'd5, 5'd4};
    rb_tab[6] = '{3'd6, 5'd4};
    rb_tab[7] = '{3'd7, 5'd4};

    eg_tab[0] = '{0, 12'hFFF, 12'h3FF};
    eg_tab[1] = '{3, 12'h000, 12'hC00};
    eg_tab[2] = '{1, 12'hC01, 12'h401};
    eg_tab[3] = '{2, 12'h2AA, 12'hAAA};

    reset = 1'b0; init = 1'b0; push_in = '0; req = 1'b0; idx = '0;
    ds_almost_full = 1'b0; umbral_alto = '0; umbral_bajo = '0;
    data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;

    // Reset values, then INIT with thresholds 6/1 and on to IDLE.
    tick(); tick();
    chk("rst_state", state, 4'b0001);
    chk("rst_data", data_out, 12'h000);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_ovf", overflow, 4'h0);
    chk("rst_ae", almost_empty_out, 4'hF);
    chk("rst_af", almost_full_out, 4'h0);
    chk("rst_cval", counter_valid, 1'b0);
    chk("rst_cout", counter_out, 5'd0);
    reset = 1'b1; init = 1'b1; umbral_alto = 3'd6; umbral_bajo = 3'd1;
    tick();
    chk("init_state", state, 4'b0010);
    tick();
    init = 1'b0;
    tick();
    chk("idle_state", state, 4'b0100);
    chk("idle_af", almost_full_out, 4'h0);
    chk("idle_ae", almost_empty_out, 4'hF);

    // Single word on port 2.
    push_port(2, 12'hABC);
    chk("t2_still_idle", state, 4'b0100);
    tick();
    chk("t2_active", state, 4'b1000);
    chk("t2_no_valid_yet", valid_out, 1'b0);
    tick();
    chk("t2_valid", valid_out, 1'b1);
    chk("t2_data", data_out, 12'hABC);
    tick();
    chk("t2_back_idle", state, 4'b0100);
    chk("t2_valid_drop", valid_out, 1'b0);
    chk("t2_data_hold", data_out, 12'hABC);

    // One word per port in one cycle: round-robin order 0..3.
    reset_init(3'd6, 3'd1);
    push_in = 4'hF;
    data_in0 = 12'hF11; data_in1 = 12'h0A5; data_in2 = 12'h5C3; data_in3 = 12'h3FF;
    tick();
    push_in = '0;
    tick();
    tick(); chk("t3_v0", valid_out, 1'b1); chk("t3_w0", data_out, 12'h311);
    tick(); chk("t3_v1", valid_out, 1'b1); chk("t3_w1", data_out, 12'h4A5);
    tick(); chk("t3_v2", valid_out, 1'b1); chk("t3_w2", data_out, 12'h9C3);
    tick(); chk("t3_v3", valid_out, 1'b1); chk("t3_w3", data_out, 12'hFFF);
    tick(); chk("t3_done", valid_out, 1'b0);
    wait_idle("t3_idle");

    // Counter readback table.
    for (int i = 0; i < 8; i++) begin
      req = 1'b1; idx = rb_tab[i].idx;
      tick();
      req = 1'b0;
      chk($sformatf("rb_valid_idx%0d", rb_tab[i].idx), counter_valid, 1'b1);
      chk($sformatf("rb_value_idx%0d", rb_tab[i].idx), counter_out, rb_tab[i].exp);
    end
    tick();
    chk("rb_valid_pulse", counter_valid, 1'b0);

    // Single-word egress table: tag replaces bits [11:10].
    for (int i = 0; i < 4; i++) begin
      push_port(eg_tab[i].port, eg_tab[i].data);
      seen = 1'b0;
      for (int c = 0; c < 8 && !seen; c++) begin
        tick();
        if (valid_out) seen = 1'b1;
      end
      chk($sformatf("eg%0d_seen", i), seen, 1'b1);
      chk($sformatf("eg%0d_data", i), data_out, eg_tab[i].exp);
      wait_idle($sformatf("eg%0d_idle", i));
    end

    // Nine pushes into port 1 under back-pressure.
    ds_almost_full = 1'b1;
    for (int k = 0; k < 9; k++) begin
      push_port(1, 12'h100 + 12'(k));
      chk($sformatf("t4_af_k%0d", k), almost_full_out[1], ((k + 1) >= 6));
      chk($sformatf("t4_ovf_k%0d", k), overflow, (k == 8) ? 4'b0010 : 4'b0000);
    end
    chk("t4_ae_full", almost_empty_out[1], 1'b0);
    chk("t4_state", state, 4'b1000);
    chk("t4_no_pop", valid_out, 1'b0);
    req = 1'b1; idx = 3'd5;
    tick();
    req = 1'b0;
    chk("t4_req_ignored", counter_valid, 1'b0);
    chk("t4_cout_hold", counter_out, 5'd4);
    ds_almost_full = 1'b0;
    nw = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (valid_out) begin
        if (nw < 8) chk($sformatf("t4_word%0d", nw), data_out, 12'h500 + 12'(nw));
        nw++;
      end
    end
    chk("t4_word_count", nw, 8);
    chk("t4_ovf_sticky", overflow, 4'b0010);
    wait_idle("t4_idle");

    // Reset while port 0 holds five words.
    ds_almost_full = 1'b1;
    for (int k = 0; k < 5; k++) push_port(0, 12'h0F0 + 12'(k));
    chk("t6_ae0_before", almost_empty_out[0], 1'b0);
    reset = 1'b0;
    tick();
    chk("t6_state", state, 4'b0001);
    chk("t6_valid", valid_out, 1'b0);
    chk("t6_data", data_out, 12'h000);
    chk("t6_ae", almost_empty_out, 4'hF);
    chk("t6_af", almost_full_out, 4'h0);
    chk("t6_ovf", overflow, 4'h0);
    chk("t6_cout", counter_out, 5'd0);
    reset_init(3'd6, 3'd1);
    tick();
    chk("t6_stays_idle", state, 4'b0100);
    chk("t6_no_egress", valid_out, 1'b0);
    req = 1'b1; idx = 3'd5;
    tick();
    chk("t6_total_zero", counter_out, 5'd0);
    chk("t6_total_valid", counter_valid, 1'b1);
    idx = 3'd1;
    tick();
    req = 1'b0;
    chk("t6_cnt1_zero", counter_out, 5'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
